// File: rtl/nonce_target_checker.sv
// Nonce target checker: scans NUM_NONCES final-hash words from shared memory,
// tracks the first nonce whose hash is below target and the minimum hash with
// its nonce, then writes a 3-word result record for software to poll.
module nonce_target_checker #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        found,
  output logic [15:0] first_nonce,
  output logic [31:0] min_hash,
  output logic [15:0] min_nonce
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_CAP  = 3'd2,
    WR0     = 3'd3,
    WR1     = 3'd4,
    WR2     = 3'd5
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_NONCES - 1);

  state_t      state, state_nx;
  logic [15:0] idx, idx_nx;
  logic [31:0] t_reg;
  logic        found_nx;
  logic [15:0] first_nonce_nx;
  logic [31:0] min_hash_nx;
  logic [15:0] min_nonce_nx;
  logic        mem_we_nx;
  logic [15:0] mem_addr_nx;
  logic [31:0] mem_write_data_nx;

  // Record word 0: found flag in the MSB, first passing nonce in the low half.
  function automatic logic [31:0] pack_word0(input logic f, input logic [15:0] n);
    return {f, 15'b0, n};
  endfunction

  assign mem_clk = clk;
  assign done    = (state == IDLE);

  // Target is captured once per accepted start; it is pure data, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start)
      t_reg <= target;
  end

  // State, scan index, results and memory port registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= 16'h0;
      found          <= 1'b0;
      first_nonce    <= 16'h0;
      min_hash       <= 32'hFFFF_FFFF;
      min_nonce      <= 16'h0;
      mem_we         <= 1'b0;
      mem_addr       <= 16'h0;
      mem_write_data <= 32'h0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      found          <= found_nx;
      first_nonce    <= first_nonce_nx;
      min_hash       <= min_hash_nx;
      min_nonce      <= min_nonce_nx;
      mem_we         <= mem_we_nx;
      mem_addr       <= mem_addr_nx;
      mem_write_data <= mem_write_data_nx;
    end
  end

  // Next-state and next-register values; every register holds by default.
  always_comb begin
    state_nx          = state;
    idx_nx            = idx;
    found_nx          = found;
    first_nonce_nx    = first_nonce;
    min_hash_nx       = min_hash;
    min_nonce_nx      = min_nonce;
    mem_we_nx         = mem_we;
    mem_addr_nx       = mem_addr;
    mem_write_data_nx = mem_write_data;

    case (state)
      IDLE: begin
        if (start) begin
          idx_nx         = 16'h0;
          found_nx       = 1'b0;
          first_nonce_nx = 16'h0;
          min_hash_nx    = 32'hFFFF_FFFF;
          min_nonce_nx   = 16'h0;
          mem_addr_nx    = hash_addr;
          state_nx       = RD_WAIT;
        end
      end

      // Synchronous memory: the word addressed on entry is ready one cycle later.
      RD_WAIT: state_nx = RD_CAP;

      RD_CAP: begin
        if ((mem_read_data < t_reg) && !found) begin
          found_nx       = 1'b1;
          first_nonce_nx = idx;
        end
        // Strict compare keeps the earlier nonce on ties.
        if (mem_read_data < min_hash) begin
          min_hash_nx  = mem_read_data;
          min_nonce_nx = idx;
        end
        if (idx == LAST_IDX) begin
          // Word 0 uses the next values so the final compare is included.
          mem_we_nx         = 1'b1;
          mem_addr_nx       = result_addr;
          mem_write_data_nx = pack_word0(found_nx, first_nonce_nx);
          state_nx          = WR0;
        end else begin
          idx_nx      = idx + 16'd1;
          mem_addr_nx = hash_addr + idx + 16'd1;
          state_nx    = RD_WAIT;
        end
      end

      WR0: begin
        mem_addr_nx       = result_addr + 16'd1;
        mem_write_data_nx = min_hash;
        state_nx          = WR1;
      end

      WR1: begin
        mem_addr_nx       = result_addr + 16'd2;
        mem_write_data_nx = {16'h0, min_nonce};
        state_nx          = WR2;
      end

      WR2: begin
        mem_we_nx = 1'b0;
        state_nx  = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nonce_target_checker.sv
// Self-checking bench for nonce_target_checker: synchronous memory model,
// directed scenarios from the plan plus randomized scans against a reference.
module tb_nonce_target_checker;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] hash_addr, result_addr;
  logic [31:0] target;
  logic        done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        found;
  logic [15:0] first_nonce, min_nonce;
  logic [31:0] min_hash;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } ld_t;

  logic [31:0] mem [65536];
  ld_t         ld_q [$];
  logic [15:0] wr_q [$];
  logic [15:0] rd_q [$];
  logic [31:0] ref_w [N];
  logic        e_found;
  logic [15:0] e_first, e_minn;
  logic [31:0] e_minh;

  always #5 clk = ~clk;

  nonce_target_checker #(.NUM_NONCES(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .hash_addr(hash_addr), .result_addr(result_addr), .target(target),
    .done(done), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .found(found), .first_nonce(first_nonce), .min_hash(min_hash),
    .min_nonce(min_nonce)
  );

  // Synchronous single-port memory; bench preloads are applied on the next edge.
  always @(posedge mem_clk) begin
    ld_t e;
    while (ld_q.size() > 0) begin
      e = ld_q.pop_front();
      mem[e.a] <= e.d;
    end
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_write_data;
      wr_q.push_back(mem_addr);
    end
    mem_read_data <= mem[mem_addr];
  end

  // Reference: first passing index is the lowest i with w<target; min keeps earliest.
  task automatic model(input logic [31:0] tg);
    e_found = 1'b0; e_first = 16'h0; e_minh = 32'hFFFF_FFFF; e_minn = 16'h0;
    for (int i = N - 1; i >= 0; i--)
      if (ref_w[i] < tg) begin e_found = 1'b1; e_first = 16'(i); end
    for (int i = 0; i < N; i++)
      if (ref_w[i] < e_minh) begin e_minh = ref_w[i]; e_minn = 16'(i); end
  endtask

  task automatic load_scan(input logic [15:0] ha, input logic [15:0] ra);
    for (int i = 0; i < N; i++) ld_q.push_back('{a: ha + 16'(i), d: ref_w[i]});
    for (int k = 0; k < 3; k++) ld_q.push_back('{a: ra + 16'(k), d: 32'hDEAD_0000 + 32'(k)});
    @(negedge clk);
  endtask

  // Start one scan and count busy cycles; optionally pulse start at busy cycle 'poke'.
  task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra,
                          input logic [31:0] tg, input int poke, output int busy);
    hash_addr = ha; result_addr = ra; target = tg;
    wr_q.delete(); rd_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy = 0;
    while (done !== 1'b1 && busy < 1000) begin
      if (mem_we === 1'b0) rd_q.push_back(mem_addr);
      busy++;
      start = (busy == poke);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (busy >= 1000) begin
      errors++;
      $display("FAIL scan_timeout busy=%0d limit=1000", busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({done, mem_we, mem_addr, mem_write_data} !== {1'b1, 1'b0, 16'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_port got %h want %h", {done, mem_we, mem_addr, mem_write_data},
               {1'b1, 1'b0, 16'h0, 32'h0});
    end
    checks++;
    if ({found, first_nonce, min_hash, min_nonce} !== {1'b0, 16'h0, 32'hFFFF_FFFF, 16'h0}) begin
      errors++;
      $display("FAIL reset_result got %h want %h", {found, first_nonce, min_hash, min_nonce},
               {1'b0, 16'h0, 32'hFFFF_FFFF, 16'h0});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ascending();
    int busy;
    for (int i = 0; i < N; i++) ref_w[i] = 32'h1000_0000 + 32'(i);
    load_scan(16'h0100, 16'h0800);
    run_scan(16'h0100, 16'h0800, 32'h1000_0005, -1, busy);
    checks++;
    if ({found, first_nonce, min_hash, min_nonce} !== {1'b1, 16'h0, 32'h1000_0000, 16'h0}) begin
      errors++;
      $display("FAIL asc_result got %h want %h", {found, first_nonce, min_hash, min_nonce},
               {1'b1, 16'h0, 32'h1000_0000, 16'h0});
    end
    checks++;
    if ({mem[16'h0800], mem[16'h0801], mem[16'h0802]} !== {32'h8000_0000, 32'h1000_0000, 32'h0}) begin
      errors++;
      $display("FAIL asc_record got %h want %h", {mem[16'h0800], mem[16'h0801], mem[16'h0802]},
               {32'h8000_0000, 32'h1000_0000, 32'h0});
    end
    checks++;
    if (busy != 35) begin
      errors++;
      $display("FAIL asc_latency got %0d want 35", busy);
    end
    checks++;
    if (wr_q.size() != 3 || wr_q[0] !== 16'h0800 || wr_q[1] !== 16'h0801 || wr_q[2] !== 16'h0802) begin
      errors++;
      $display("FAIL asc_writes got n=%0d first=%h want n=3 first=0800", wr_q.size(), wr_q[0]);
    end
  endtask

  task automatic test_descending();
    int busy;
    for (int i = 0; i < N; i++) ref_w[i] = 32'hF000_0000 - 32'(i);
    load_scan(16'h0200, 16'h0900);
    run_scan(16'h0200, 16'h0900, 32'h0000_0001, -1, busy);
    checks++;
    if ({found, first_nonce, min_hash, min_nonce} !== {1'b0, 16'h0, 32'hEFFF_FFF1, 16'd15}) begin
      errors++;
      $display("FAIL desc_result got %h want %h", {found, first_nonce, min_hash, min_nonce},
               {1'b0, 16'h0, 32'hEFFF_FFF1, 16'd15});
    end
    checks++;
    if ({mem[16'h0900], mem[16'h0901], mem[16'h0902]} !== {32'h0, 32'hEFFF_FFF1, 32'd15}) begin
      errors++;
      $display("FAIL desc_record got %h want %h", {mem[16'h0900], mem[16'h0901], mem[16'h0902]},
               {32'h0, 32'hEFFF_FFF1, 32'd15});
    end
  endtask

  task automatic test_tie();
    int busy;
    for (int i = 0; i < N; i++) ref_w[i] = 32'hFFFF_FFFF;
    ref_w[9] = 32'h10; ref_w[12] = 32'h10;
    load_scan(16'h0300, 16'h0A00);
    run_scan(16'h0300, 16'h0A00, 32'h11, -1, busy);
    checks++;
    if ({found, first_nonce, min_hash, min_nonce} !== {1'b1, 16'd9, 32'h10, 16'd9}) begin
      errors++;
      $display("FAIL tie_result got %h want %h", {found, first_nonce, min_hash, min_nonce},
               {1'b1, 16'd9, 32'h10, 16'd9});
    end
  endtask

  task automatic test_target_bounds();
    int busy;
    // All-ones words: nothing passes even the largest target, min stays at nonce 0.
    for (int i = 0; i < N; i++) ref_w[i] = 32'hFFFF_FFFF;
    load_scan(16'h0400, 16'h0B00);
    run_scan(16'h0400, 16'h0B00, 32'hFFFF_FFFF, -1, busy);
    checks++;
    if ({found, first_nonce, min_hash, min_nonce} !== {1'b0, 16'h0, 32'hFFFF_FFFF, 16'h0}) begin
      errors++;
      $display("FAIL allones_result got %h want %h", {found, first_nonce, min_hash, min_nonce},
               {1'b0, 16'h0, 32'hFFFF_FFFF, 16'h0});
    end
    ref_w[13] = 32'hFFFF_FFFE;
    load_scan(16'h0400, 16'h0B00);
    run_scan(16'h0400, 16'h0B00, 32'hFFFF_FFFF, -1, busy);
    checks++;
    if ({found, first_nonce, min_hash, min_nonce} !== {1'b1, 16'd13, 32'hFFFF_FFFE, 16'd13}) begin
      errors++;
      $display("FAIL maxtarget_result got %h want %h", {found, first_nonce, min_hash, min_nonce},
               {1'b1, 16'd13, 32'hFFFF_FFFE, 16'd13});
    end
    for (int i = 0; i < N; i++) ref_w[i] = 32'(i);
    load_scan(16'h0400, 16'h0B00);
    run_scan(16'h0400, 16'h0B00, 32'h0, -1, busy);
    checks++;
    if ({found, first_nonce, min_hash, min_nonce} !== {1'b0, 16'h0, 32'h0, 16'h0}) begin
      errors++;
      $display("FAIL zerotarget_result got %h want %h", {found, first_nonce, min_hash, min_nonce},
               {1'b0, 16'h0, 32'h0, 16'h0});
    end
  endtask

  task automatic test_random();
    int busy;
    logic [15:0] ha, ra;
    logic [31:0] tg;
    for (int it = 0; it < 6; it++) begin
      ha = 16'($urandom_range(0, 16'h7FFF));
      ra = ha + 16'h1000;
      if (it % 2 == 0) begin
        tg = $urandom;
        for (int i = 0; i < N; i++) ref_w[i] = $urandom;
      end else begin
        tg = 32'd105;
        for (int i = 0; i < N; i++) ref_w[i] = 32'd100 + 32'($urandom_range(0, 15));
      end
      load_scan(ha, ra);
      run_scan(ha, ra, tg, -1, busy);
      model(tg);
      checks++;
      if ({found, first_nonce, min_hash, min_nonce} !== {e_found, e_first, e_minh, e_minn}) begin
        errors++;
        $display("FAIL rand%0d_result got %h want %h", it, {found, first_nonce, min_hash, min_nonce},
                 {e_found, e_first, e_minh, e_minn});
      end
      checks++;
      if ({mem[ra], mem[ra + 16'd1], mem[ra + 16'd2]} !== {e_found, 15'b0, e_first, e_minh, 16'h0, e_minn}) begin
        errors++;
        $display("FAIL rand%0d_record got %h want %h", it, {mem[ra], mem[ra + 16'd1], mem[ra + 16'd2]},
                 {e_found, 15'b0, e_first, e_minh, 16'h0, e_minn});
      end
    end
  endtask

  task automatic test_busy_start();
    int busy, hi;
    for (int i = 0; i < N; i++) ref_w[i] = 32'h5000_0000 - 32'(i * 3);
    load_scan(16'h0500, 16'h0C00);
    // Busy cycle 10 is the read-capture cycle of nonce 4.
    run_scan(16'h0500, 16'h0C00, 32'h4FFF_FFF0, 10, busy);
    model(32'h4FFF_FFF0);
    checks++;
    if (busy != 35 || wr_q.size() != 3) begin
      errors++;
      $display("FAIL busystart_len got busy=%0d writes=%0d want busy=35 writes=3", busy, wr_q.size());
    end
    checks++;
    if ({found, first_nonce, min_hash, min_nonce} !== {e_found, e_first, e_minh, e_minn}) begin
      errors++;
      $display("FAIL busystart_result got %h want %h", {found, first_nonce, min_hash, min_nonce},
               {e_found, e_first, e_minh, e_minn});
    end
    hi = 0;
    repeat (3) begin @(negedge clk); if (done === 1'b1) hi++; end
    checks++;
    if (hi != 3) begin
      errors++;
      $display("FAIL busystart_idle got %0d idle cycles want 3", hi);
    end
  endtask

  task automatic test_wrap();
    int busy;
    for (int i = 0; i < N; i++) ref_w[i] = 32'h0A00_0000 ^ 32'(i * 7 + 3);
    load_scan(16'hFFF8, 16'h0D00);
    run_scan(16'hFFF8, 16'h0D00, 32'h0A00_0010, -1, busy);
    model(32'h0A00_0010);
    checks++;
    if ({found, first_nonce, min_hash, min_nonce} !== {e_found, e_first, e_minh, e_minn}) begin
      errors++;
      $display("FAIL wrap_result got %h want %h", {found, first_nonce, min_hash, min_nonce},
               {e_found, e_first, e_minh, e_minn});
    end
    checks++;
    if (rd_q.size() != 2 * N) begin
      errors++;
      $display("FAIL wrap_readcycles got %0d want %0d", rd_q.size(), 2 * N);
    end
    // Every address is held for a wait cycle and a capture cycle with mem_we low.
    for (int k = 0; k < 2 * N && k < rd_q.size(); k++) begin
      checks++;
      if (rd_q[k] !== 16'hFFF8 + 16'(k / 2)) begin
        errors++;
        $display("FAIL wrap_addr%0d got %h want %h", k, rd_q[k], 16'hFFF8 + 16'(k / 2));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    for (int i = 0; i < N; i++) ref_w[i] = 32'h2000_0000 + 32'(i * 11);
    ref_w[6] = 32'h0000_1234;
    load_scan(16'h0600, 16'h0E00);
    model(32'h0001_0000);
    hash_addr = 16'h0600; result_addr = 16'h0E00; target = 32'h0001_0000;
    wr_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr === 16'h0E01) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL rstwr_reach got timeout want WR1 within 200 cycles");
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, done, found, min_hash} !== {1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL rstwr_state got %h want %h", {mem_we, done, found, min_hash},
               {1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF});
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({mem[16'h0E00], mem[16'h0E01], mem[16'h0E02]} !==
        {e_found, 15'b0, e_first, 32'hDEAD_0001, 32'hDEAD_0002} || wr_q.size() != 1) begin
      errors++;
      $display("FAIL rstwr_record got %h writes=%0d want %h writes=1",
               {mem[16'h0E00], mem[16'h0E01], mem[16'h0E02]}, wr_q.size(),
               {e_found, 15'b0, e_first, 32'hDEAD_0001, 32'hDEAD_0002});
    end
  endtask

  task automatic test_back_to_back();
    int b1, b2, idle;
    for (int i = 0; i < N; i++) ref_w[i] = $urandom;
    load_scan(16'h0700, 16'h0F00);
    model(32'h8000_0000);
    hash_addr = 16'h0700; result_addr = 16'h0F00; target = 32'h8000_0000;
    wr_q.delete();
    start = 1'b1;
    @(negedge clk);
    b1 = 0;
    while (done === 1'b0 && b1 < 1000) begin b1++; @(negedge clk); end
    idle = 0;
    while (done === 1'b1 && idle < 10) begin idle++; @(negedge clk); end
    start = 1'b0;
    b2 = 0;
    while (done === 1'b0 && b2 < 1000) begin b2++; @(negedge clk); end
    checks++;
    if (b1 != 35 || idle != 1 || b2 != 35 || wr_q.size() != 6) begin
      errors++;
      $display("FAIL b2b_timing got b1=%0d idle=%0d b2=%0d writes=%0d want 35 1 35 6",
               b1, idle, b2, wr_q.size());
    end
    checks++;
    if ({found, first_nonce, min_hash, min_nonce} !== {e_found, e_first, e_minh, e_minn}) begin
      errors++;
      $display("FAIL b2b_result got %h want %h", {found, first_nonce, min_hash, min_nonce},
               {e_found, e_first, e_minh, e_minn});
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0;
    hash_addr = 16'h0; result_addr = 16'h0; target = 32'h0;
    test_reset();
    test_ascending();
    test_descending();
    test_tie();
    test_target_bounds();
    test_random();
    test_busy_start();
    test_wrap();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
